// File: rtl/tdm_pkg.sv
// Shared constants and types for the 16-channel TDM link (receive demux and
// the transmit-side select sweep).
package tdm_pkg;

   localparam int NUM_CHANNELS = 16;
   localparam int CHANNEL_W    = 4;
   localparam logic [CHANNEL_W-1:0] LAST_CHANNEL = CHANNEL_W'(NUM_CHANNELS - 1);

   // The transmit-side select counter sweeps the same range.
   localparam int TX_NUM_SEL = NUM_CHANNELS;
   localparam int TX_SEL_W   = CHANNEL_W;
   localparam logic [TX_SEL_W-1:0] TX_LAST_SEL = TX_SEL_W'(TX_NUM_SEL - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/tdm_demux_1_16_if.sv
// Serial input / parallel frame output bundle for the TDM demux. There is no
// backpressure: a sample is taken on every edge with Enable_In and Data_Valid_In high.
interface tdm_demux_1_16_if;
   import tdm_pkg::*;

   logic                    Enable_In;
   logic                    Data_Valid_In;
   logic                    Frame_Sync_In;
   logic                    Serial_Data_In;
   logic                    Error_Clear_In;
   logic [NUM_CHANNELS-1:0] Data_Out;
   logic [CHANNEL_W-1:0]    Channel_Out;
   logic                    Frame_Done_Out;
   logic                    Frame_Error_Out;
   state_t                  State_Out;

   modport master (
      output Enable_In, Data_Valid_In, Frame_Sync_In, Serial_Data_In, Error_Clear_In,
      input  Data_Out, Channel_Out, Frame_Done_Out, Frame_Error_Out, State_Out
   );

   modport slave (
      input  Enable_In, Data_Valid_In, Frame_Sync_In, Serial_Data_In, Error_Clear_In,
      output Data_Out, Channel_Out, Frame_Done_Out, Frame_Error_Out, State_Out
   );

endinterface

// File: rtl/demux_1_16_decode.sv
// One-hot write-enable decoder: selects the single shadow bit written this cycle.
module demux_1_16_decode
   import tdm_pkg::*;
(
   input  logic                    accept,
   input  logic [CHANNEL_W-1:0]    sel,
   output logic [NUM_CHANNELS-1:0] we
);

   always_comb begin
      we = '0;
      if (accept) we[sel] = 1'b1;
   end

endmodule

// File: rtl/tdm_demux_1_16.sv
// 1:16 TDM demultiplexer: aligns on frame sync, assembles samples in a shadow
// register and commits whole frames to Data_Out.
module tdm_demux_1_16
   import tdm_pkg::*;
(
   input  logic             Clock_In,
   input  logic             Reset_In,
   tdm_demux_1_16_if.slave  bus
);

   state_t                  state;
   logic [CHANNEL_W-1:0]    channel;
   logic [NUM_CHANNELS-1:0] shadow;
   logic [NUM_CHANNELS-1:0] data_q;
   logic                    done_q;
   logic                    err_q;

   logic                    accept;
   logic                    sync_acc;
   logic                    misalign;
   logic                    wr_en;
   logic [CHANNEL_W-1:0]    wr_sel;
   logic                    commit;
   logic [NUM_CHANNELS-1:0] bit_we;

   assign accept   = bus.Enable_In & bus.Data_Valid_In;
   assign sync_acc = accept & bus.Frame_Sync_In;
   assign misalign = sync_acc & (state == RUN) & (channel != '0);
   // A sync always forces channel 0, even mid-frame; unsynced samples in IDLE are dropped.
   assign wr_en    = accept & (bus.Frame_Sync_In | (state == RUN));
   assign wr_sel   = bus.Frame_Sync_In ? '0 : channel;
   assign commit   = accept & ~bus.Frame_Sync_In & (state == RUN) & (channel == LAST_CHANNEL);

   demux_1_16_decode u_decode (
      .accept (wr_en),
      .sel    (wr_sel),
      .we     (bit_we)
   );

   always_ff @(posedge Clock_In) begin
      if (Reset_In) begin
         state   <= IDLE;
         channel <= '0;
         shadow  <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else if (bus.Enable_In) begin
         shadow <= (shadow & ~bit_we) | (bit_we & {NUM_CHANNELS{bus.Serial_Data_In}});
         done_q <= commit;
         // Bit 15 comes straight from the input so the frame lands in one edge.
         if (commit) data_q <= {bus.Serial_Data_In, shadow[NUM_CHANNELS-2:0]};
         if (sync_acc) begin
            state   <= RUN;
            channel <= CHANNEL_W'(1);
         end else if (accept && (state == RUN)) begin
            channel <= channel + 1'b1;
         end
         if (misalign)                err_q <= 1'b1;
         else if (bus.Error_Clear_In) err_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
      end
   end

   assign bus.Data_Out        = data_q;
   assign bus.Channel_Out     = channel;
   assign bus.Frame_Done_Out  = done_q;
   assign bus.Frame_Error_Out = err_q;
   assign bus.State_Out       = state;

endmodule

// File: tb/tb_tdm_demux_1_16.sv
// Bench for tdm_demux_1_16: directed scenarios plus random traffic, checked
// against a queue-based frame model and a frame scoreboard.
module tb_tdm_demux_1_16;
   import tdm_pkg::*;

   logic clk;
   logic rst;
   tdm_demux_1_16_if bus ();

   tdm_demux_1_16 dut (
      .Clock_In (clk),
      .Reset_In (rst),
      .bus      (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model state
   bit          cur_q[$];
   bit          locked;
   logic        exp_err;
   logic        exp_done;
   logic [15:0] exp_data;
   logic [15:0] exp_q[$];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_apply(input logic en, input logic v, input logic s,
                              input logic d, input logic c, input logic r);
      logic        err_set;
      logic [15:0] w;
      err_set  = 1'b0;
      exp_done = 1'b0;
      if (r) begin
         cur_q.delete();
         locked   = 1'b0;
         exp_err  = 1'b0;
         exp_data = '0;
      end else if (en) begin
         if (v && s) begin
            if (locked && cur_q.size() != 0) err_set = 1'b1;
            cur_q.delete();
            cur_q.push_back(d);
            locked = 1'b1;
         end else if (v && locked) begin
            cur_q.push_back(d);
            if (cur_q.size() == 16) begin
               w = '0;
               for (int i = 0; i < 16; i++) w[i] = cur_q[i];
               exp_q.push_back(w);
               exp_data = w;
               exp_done = 1'b1;
               cur_q.delete();
            end
         end
         if (err_set) exp_err = 1'b1;
         else if (c)  exp_err = 1'b0;
      end
   endtask

   // driver: apply one cycle of inputs, then check after the edge
   task automatic step(input logic en, input logic v, input logic s,
                       input logic d, input logic c, input logic r);
      bus.Enable_In      = en;
      bus.Data_Valid_In  = v;
      bus.Frame_Sync_In  = s;
      bus.Serial_Data_In = d;
      bus.Error_Clear_In = c;
      rst                = r;
      model_apply(en, v, s, d, c, r);
      @(posedge clk);
      #1;
      chk("channel", 16'(bus.Channel_Out), 16'(cur_q.size()));
      chk("error",   16'(bus.Frame_Error_Out), 16'(exp_err));
      chk("done",    16'(bus.Frame_Done_Out), 16'(exp_done));
      chk("data",    bus.Data_Out, exp_data);
      chk("state",   16'(bus.State_Out), locked ? 16'(RUN) : 16'(IDLE));
   endtask

   task automatic send_frame(input logic [15:0] w, input logic sync_first);
      for (int i = 0; i < 16; i++) step(1'b1, 1'b1, (i == 0) && sync_first, w[i], 1'b0, 1'b0);
   endtask

   task automatic send_bits(input int n, input logic sync_first);
      for (int i = 0; i < n; i++)
         step(1'b1, 1'b1, (i == 0) && sync_first, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
   endtask

   // monitor / scoreboard: every frame pulse must match the oldest expected frame
   always @(negedge clk) begin
      if (bus.Frame_Done_Out === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame_unexpected: got %h expected none at %0t", bus.Data_Out, $time);
         end else begin
            chk("frame", bus.Data_Out, exp_q.pop_front());
         end
      end
   end

   initial begin
      bus.Enable_In = 0; bus.Data_Valid_In = 0; bus.Frame_Sync_In = 0;
      bus.Serial_Data_In = 0; bus.Error_Clear_In = 0; rst = 1;
      locked = 0; exp_err = 0; exp_done = 0; exp_data = '0;

      // reset values
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("rst_data", bus.Data_Out, 16'h0000);

      // sync-led frame 1,0,1,1,0..0,1
      send_frame(16'h800D, 1'b1);
      chk("t1_data", bus.Data_Out, 16'h800D);
      chk("t1_done", 16'(bus.Frame_Done_Out), 16'd1);
      chk("t1_ch",   16'(bus.Channel_Out), 16'd0);
      step(0, 0, 0, 0, 0, 0);
      chk("t1_done_pulse", 16'(bus.Frame_Done_Out), 16'd0);

      // unsynced samples after reset are discarded
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++) step(1, 1, 0, 1, 0, 0);
      chk("nosync_data", bus.Data_Out, 16'h0000);
      chk("nosync_ch",   16'(bus.Channel_Out), 16'd0);

      // back-to-back frames, sync only on the first
      send_frame(16'hFFFF, 1'b1);
      chk("b2b_first", bus.Data_Out, 16'hFFFF);
      send_frame(16'h00F0, 1'b0);
      chk("b2b_second", bus.Data_Out, 16'h00F0);
      chk("b2b_done",   16'(bus.Frame_Done_Out), 16'd1);

      // misaligned sync at channel 5
      send_bits(5, 1'b0);
      chk("mis_pre_ch", 16'(bus.Channel_Out), 16'd5);
      step(1, 1, 1, 1, 0, 0);
      chk("mis_err",  16'(bus.Frame_Error_Out), 16'd1);
      chk("mis_ch",   16'(bus.Channel_Out), 16'd1);
      chk("mis_data", bus.Data_Out, 16'h00F0);
      send_bits(3, 1'b0);
      step(1, 1, 1, 0, 1, 0);
      chk("clr_vs_set", 16'(bus.Frame_Error_Out), 16'd1);
      step(1, 0, 0, 0, 1, 0);
      chk("clr_alone", 16'(bus.Frame_Error_Out), 16'd0);

      // enable low for 3 cycles at channel 7
      send_bits(15, 1'b1);
      send_bits(7, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(0, 1'(i % 2 == 0), 1'(i == 1), 1, 0, 0);
         chk("en_hold_ch", 16'(bus.Channel_Out), 16'd7);
      end
      send_bits(9, 1'b0);
      chk("en_done", 16'(bus.Frame_Done_Out), 16'd1);

      // reset at channel 10
      send_bits(10, 1'b1);
      chk("pre_rst_ch", 16'(bus.Channel_Out), 16'd10);
      step(1, 1, 0, 1, 0, 1);
      chk("rst_mid_data",  bus.Data_Out, 16'h0000);
      chk("rst_mid_ch",    16'(bus.Channel_Out), 16'd0);
      chk("rst_mid_state", 16'(bus.State_Out), 16'(IDLE));
      send_frame(16'hA5C3, 1'b1);
      chk("post_rst_frame", bus.Data_Out, 16'hA5C3);

      // random traffic
      for (int i = 0; i < 1500; i++)
         step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 7) != 0),
              1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 399) == 0));

      @(negedge clk);
      chk("drain", 16'(exp_q.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
